// File: rtl/timer_periph_if.sv
// Data-bus slice seen by the timer block: LSU address/store strobe in, read data and interrupts out.
interface timer_periph_if #(
  parameter int unsigned N_TIMERS = 4
);
  logic [31:0]         addr;
  logic [31:0]         wdata;
  logic                we;
  logic [31:0]         rdata;
  logic [N_TIMERS-1:0] irq;

  modport master (output addr, wdata, we, input rdata, irq);
  modport slave  (input addr, wdata, we, output rdata, irq);
endinterface

// File: rtl/timer_periph.sv
// Bank of memory-mapped down-counting timers with prescaler, reload, one-shot/auto-reload
// modes and sticky expiry flags; reads are combinational, writes land at the clock edge.
module timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
  parameter int unsigned N_TIMERS  = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PS_W      = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  timer_periph_if.slave  bus
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q [N_TIMERS];
  state_t              state_n [N_TIMERS];
  logic [PS_W-1:0]     pre_q   [N_TIMERS];
  logic [PS_W-1:0]     pre_n   [N_TIMERS];
  logic [PS_W-1:0]     ps_q    [N_TIMERS];
  logic [PS_W-1:0]     ps_n    [N_TIMERS];
  logic [CNT_W-1:0]    load_q  [N_TIMERS];
  logic [CNT_W-1:0]    load_n  [N_TIMERS];
  logic [CNT_W-1:0]    count_q [N_TIMERS];
  logic [CNT_W-1:0]    count_n [N_TIMERS];
  logic [N_TIMERS-1:0] auto_q, auto_n;
  logic [N_TIMERS-1:0] irq_en_q, irq_en_n;
  logic [N_TIMERS-1:0] exp_q, exp_n;

  logic                sel;
  logic                t_ok;
  logic [1:0]          t_idx;
  logic [1:0]          r_idx;
  logic [N_TIMERS-1:0] wr_ctrl, wr_load, wr_stat, tick, frz, expire;
  logic                unused;

  assign sel    = (bus.addr[31:6] == BASE_ADDR[31:6]);
  assign t_idx  = bus.addr[5:4];
  assign r_idx  = bus.addr[3:2];
  assign t_ok   = sel && (32'(t_idx) < N_TIMERS);
  assign unused = ^{bus.addr[1:0], bus.wdata};

  // Per-timer write strobes and tick/expiry qualification
  for (genvar gi = 0; gi < N_TIMERS; gi++) begin : g_dec
    logic hit;
    assign hit          = bus.we && t_ok && (t_idx == 2'(gi));
    assign wr_ctrl[gi]  = hit && (r_idx == REG_CTRL);
    assign wr_load[gi]  = hit && (r_idx == REG_LOAD);
    assign wr_stat[gi]  = hit && (r_idx == REG_STATUS);
    assign tick[gi]     = (state_q[gi] == RUN) && (ps_q[gi] == pre_q[gi]);
    // Disabling write freezes the timer, so a coincident tick is discarded
    assign frz[gi]      = wr_ctrl[gi] && !bus.wdata[0];
    assign expire[gi]   = tick[gi] && (count_q[gi] == CNT_W'(1)) && !wr_load[gi] && !frz[gi];
  end

  // Next-state: counting, expiry, then register writes layered on top
  always_comb begin
    auto_n   = auto_q;
    irq_en_n = irq_en_q;
    exp_n    = exp_q;
    for (int i = 0; i < N_TIMERS; i++) begin
      state_n[i] = state_q[i];
      pre_n[i]   = pre_q[i];
      ps_n[i]    = ps_q[i];
      load_n[i]  = load_q[i];
      count_n[i] = count_q[i];
    end

    for (int i = 0; i < N_TIMERS; i++) begin
      if (wr_load[i]) begin
        load_n[i]  = CNT_W'(bus.wdata);
        count_n[i] = CNT_W'(bus.wdata);
        ps_n[i]    = '0;
      end else if (!frz[i]) begin
        if (tick[i]) begin
          ps_n[i] = '0;
          if (count_q[i] > CNT_W'(1)) begin
            count_n[i] = count_q[i] - CNT_W'(1);
          end else if (expire[i]) begin
            if (auto_q[i]) begin
              count_n[i] = load_q[i];
            end else begin
              count_n[i] = '0;
              state_n[i] = IDLE;
            end
          end
        end else if (state_q[i] == RUN) begin
          ps_n[i] = ps_q[i] + PS_W'(1);
        end
      end

      if (wr_ctrl[i]) begin
        auto_n[i]   = bus.wdata[1];
        irq_en_n[i] = bus.wdata[2];
        pre_n[i]    = PS_W'(bus.wdata[15:8]);
        if (!bus.wdata[0]) begin
          state_n[i] = IDLE;
        end else begin
          state_n[i] = RUN;
          if (state_q[i] == IDLE) ps_n[i] = '0;
        end
      end

      if (expire[i])                          exp_n[i] = 1'b1;
      else if (wr_stat[i] && bus.wdata[0])    exp_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        state_q[i] <= IDLE;
        pre_q[i]   <= '0;
        ps_q[i]    <= '0;
        load_q[i]  <= '0;
        count_q[i] <= '0;
      end
      auto_q   <= '0;
      irq_en_q <= '0;
      exp_q    <= '0;
    end else begin
      for (int i = 0; i < N_TIMERS; i++) begin
        state_q[i] <= state_n[i];
        pre_q[i]   <= pre_n[i];
        ps_q[i]    <= ps_n[i];
        load_q[i]  <= load_n[i];
        count_q[i] <= count_n[i];
      end
      auto_q   <= auto_n;
      irq_en_q <= irq_en_n;
      exp_q    <= exp_n;
    end
  end

  // Read mux for the single-cycle load path
  always_comb begin
    bus.rdata = '0;
    if (t_ok) begin
      case (r_idx)
        REG_CTRL:   bus.rdata = {16'b0, 8'(pre_q[t_idx]), 5'b0, irq_en_q[t_idx],
                                 auto_q[t_idx], (state_q[t_idx] == RUN)};
        REG_LOAD:   bus.rdata = 32'(load_q[t_idx]);
        REG_COUNT:  bus.rdata = 32'(count_q[t_idx]);
        REG_STATUS: bus.rdata = {31'b0, exp_q[t_idx]};
      endcase
    end
  end

  assign bus.irq = exp_q & irq_en_q;

endmodule

// File: tb/tb_timer_periph.sv
// Bench for timer_periph: register-map vector table, directed timing sequences, and random
// bus traffic compared against a cycle-level behavioural model of the timers.
module tb_timer_periph;

  localparam int unsigned NT   = 4;
  localparam logic [31:0] BASE = 32'h0000_4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_periph_if #(.N_TIMERS(NT)) bus ();

  timer_periph #(.BASE_ADDR(BASE), .N_TIMERS(NT), .CNT_W(32), .PS_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_en   [NT];
  bit          m_auto [NT];
  bit          m_ie   [NT];
  bit          m_exp  [NT];
  logic [7:0]  m_pre  [NT];
  logic [7:0]  m_ps   [NT];
  logic [31:0] m_load [NT];
  logic [31:0] m_cnt  [NT];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [31:0] a, input logic [31:0] d,
                                  input logic we, input logic [31:0] e);
    vec_t v;
    v.addr = a; v.wdata = d; v.we = we; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic bit m_sel(input logic [31:0] a);
    return (a >> 6) == (BASE >> 6);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int t, r;
    if (!m_sel(a)) return 32'h0;
    t = int'(a[5:4]);
    r = int'(a[3:2]);
    case (r)
      0: return {16'h0, m_pre[t], 5'b0, m_ie[t], m_auto[t], m_en[t]};
      1: return m_load[t];
      2: return m_cnt[t];
      default: return {31'b0, m_exp[t]};
    endcase
  endfunction

  function automatic logic [31:0] model_irq();
    logic [31:0] v = 32'h0;
    for (int t = 0; t < NT; t++) v[t] = m_exp[t] & m_ie[t];
    return v;
  endfunction

  // One clock of the timer rules, applied to whatever the bus presents at this edge
  task automatic model_edge();
    logic [31:0] a, wd;
    a  = bus.addr;
    wd = bus.wdata;
    for (int t = 0; t < NT; t++) begin
      bit hit, tick, fired, was_en, ctrl;
      int r;
      if (rst) begin
        m_en[t] = 0; m_auto[t] = 0; m_ie[t] = 0; m_exp[t] = 0;
        m_pre[t] = 0; m_ps[t] = 0; m_load[t] = 0; m_cnt[t] = 0;
        continue;
      end
      hit    = bus.we && m_sel(a) && (int'(a[5:4]) == t);
      r      = int'(a[3:2]);
      tick   = m_en[t] && (m_ps[t] == m_pre[t]);
      fired  = 0;
      was_en = m_en[t];
      ctrl   = hit && (r == 0);
      if (hit && r == 1) begin
        m_load[t] = wd; m_cnt[t] = wd; m_ps[t] = 0;
      end else begin
        if (!(ctrl && !wd[0])) begin
          if (tick) begin
            m_ps[t] = 0;
            if (m_cnt[t] > 1) m_cnt[t] = m_cnt[t] - 1;
            else if (m_cnt[t] == 1) begin
              fired = 1;
              m_exp[t] = 1;
              if (m_auto[t]) m_cnt[t] = m_load[t];
              else begin m_cnt[t] = 0; m_en[t] = 0; end
            end
          end else if (m_en[t]) m_ps[t] = m_ps[t] + 8'd1;
        end
        if (ctrl) begin
          m_auto[t] = wd[1]; m_ie[t] = wd[2]; m_pre[t] = wd[15:8]; m_en[t] = wd[0];
          if (wd[0] && !was_en) m_ps[t] = 0;
        end
      end
      if (hit && r == 3 && wd[0] && !fired) m_exp[t] = 0;
    end
  endtask

  task automatic clock();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.we = 1'b0;
    for (int i = 0; i < n; i++) clock();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    clock();
    bus.we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] e);
    bus.addr = a; bus.we = 1'b0;
    #1;
    chk(name, bus.rdata, e);
  endtask

  task automatic wait_irq(input int bitn, input int limit, output int n);
    n = 0;
    while (n < limit && !bus.irq[bitn]) begin
      idle(1);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] a, d;

    rst = 1'b1; bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
    #1;
    idle(2);
    rst = 1'b0;

    // Register-map vectors from reset
    for (int i = 0; i < 16; i++) add_vec(BASE + 32'(i * 4), 32'h0, 1'b0, 32'h0);
    add_vec(BASE + 32'h40, 32'h0,        1'b0, 32'h0);
    add_vec(BASE + 32'h08, 32'h1234,     1'b1, 32'h0);
    add_vec(BASE + 32'h08, 32'h0,        1'b0, 32'h0);
    add_vec(BASE + 32'h04, 32'h77,       1'b1, 32'h0);
    add_vec(BASE + 32'h05, 32'h0,        1'b0, 32'h77);
    add_vec(BASE + 32'h08, 32'h0,        1'b0, 32'h77);
    add_vec(BASE + 32'h00, 32'hFFFFFF00, 1'b1, 32'h0);
    add_vec(BASE + 32'h00, 32'h0,        1'b0, 32'h0000FF00);
    add_vec(BASE + 32'h3C, 32'hFFFFFFFF, 1'b1, 32'h0);
    add_vec(BASE + 32'h3C, 32'h0,        1'b0, 32'h0);
    add_vec(BASE + 32'h00, 32'h0,        1'b1, 32'h0);
    add_vec(BASE + 32'h04, 32'h0,        1'b1, 32'h0);
    add_vec(BASE + 32'h00, 32'h0,        1'b0, 32'h0);
    add_vec(BASE + 32'h08, 32'h0,        1'b0, 32'h0);
    chk("irq_reset", 32'(bus.irq), 32'h0);
    foreach (vecs[i]) begin
      bus.addr = vecs[i].addr; bus.wdata = vecs[i].wdata; bus.we = vecs[i].we;
      if (vecs[i].we) clock();
      else begin
        #1;
        chk($sformatf("vec%0d", i), bus.rdata, vecs[i].exp);
      end
      bus.we = 1'b0;
    end

    // One-shot countdown, prescale 0
    wr(BASE + 32'h04, 32'd5);
    wr(BASE + 32'h00, 32'h1);
    for (int k = 5; k >= 0; k--) begin
      rd_chk($sformatf("oneshot_cnt%0d", k), BASE + 32'h08, 32'(k));
      if (k > 0) idle(1);
    end
    rd_chk("oneshot_exp", BASE + 32'h0C, 32'h1);
    rd_chk("oneshot_ctrl", BASE + 32'h00, 32'h0);
    idle(3);
    rd_chk("oneshot_hold", BASE + 32'h08, 32'h0);

    // Auto-reload with prescale 2: 9-cycle period, W1C clears the interrupt
    wr(BASE + 32'h14, 32'd3);
    wr(BASE + 32'h10, 32'h0207);
    wait_irq(1, 20, n);
    chk("auto_period1", 32'(n), 32'd9);
    rd_chk("auto_reload", BASE + 32'h18, 32'd3);
    wr(BASE + 32'h1C, 32'h1);
    chk("w1c_irq", 32'(bus.irq[1]), 32'h0);
    wait_irq(1, 20, n);
    chk("auto_period2", 32'(n), 32'd8);

    // W1C coinciding with expiry, then LOAD coinciding with a tick
    idle(8);
    wr(BASE + 32'h1C, 32'h1);
    rd_chk("w1c_vs_expiry", BASE + 32'h1C, 32'h1);
    idle(2);
    wr(BASE + 32'h14, 32'd7);
    rd_chk("load_vs_tick", BASE + 32'h18, 32'd7);
    idle(3);
    rd_chk("load_restart", BASE + 32'h18, 32'd6);

    // COUNT is read-only; reset mid-run clears everything
    wr(BASE + 32'h18, 32'h1234);
    rd_chk("count_ro", BASE + 32'h18, 32'd6);
    rst = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("rst_reg%0d", i), BASE + 32'(i * 4), 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    rst = 1'b0;

    // Four timers phase-aligned by enabling them one period apart
    for (int t = 0; t < NT; t++) wr(BASE + 32'(t * 16 + 4), 32'd4);
    for (int t = 0; t < NT; t++) begin
      wr(BASE + 32'(t * 16), 32'h7);
      if (t < NT - 1) idle(3);
    end
    n = 0;
    while (n < 20 && bus.irq != 4'hF) begin idle(1); n++; end
    chk("all_irq", 32'(bus.irq), 32'hF);
    for (int t = 0; t < NT; t++) begin
      rd_chk($sformatf("align_cnt%0d", t), BASE + 32'(t * 16 + 8), 32'(4 - t));
      idle(1);
    end

    // Random traffic against the model
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int t, r;
      t = int'($urandom_range(0, 4));
      r = int'($urandom_range(0, 3));
      a = BASE + 32'(t * 16 + r * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      case (r)
        0: d = {($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0,
                8'($urandom_range(0, 3)), 5'($urandom),
                3'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0)};
        1: d = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 12));
        default: d = $urandom;
      endcase
      bus.addr  = a;
      bus.wdata = d;
      bus.we    = ($urandom_range(0, 9) < 3);
      rst       = ($urandom_range(0, 499) == 0);
      #1;
      chk($sformatf("rnd_rdata@%0d a=%h", c, a), bus.rdata, model_read(a));
      chk($sformatf("rnd_irq@%0d", c), 32'(bus.irq), model_irq());
      clock();
    end
    rst = 1'b0;
    bus.we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
